dmem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory port.
- Provides a word-organised data RAM behind a valid/ready request and response handshake.
- Supports programmable wait states, byte-enabled writes and error signalling for bad addresses.
- Sits between the datapath's load/store address/data outputs and the data storage. It lets the core, or a future multi-cycle core, run against a non-zero-latency memory.

---
 rtl/dmem_responder.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Memory-side responder for the processor's data-memory port. It holds a
// word-organised data RAM behind a valid/ready request/response handshake,
// inserts LATENCY wait states between request acceptance and response,
// supports byte-enabled stores, and flags misaligned or out-of-range
// addresses with rsp_err. At most one request is outstanding at a time.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, 4..65536)
//   LATENCY  wait-state cycles between acceptance and response (0..15)
//
// Ports
//   clk        clock, all state updates on its rising edge
//   rst        synchronous active-high reset (clears control state and RAM)
//   req_valid  request present
//   req_ready  responder can accept a request (registered)
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     byte enables, bit i covers bits 8i+7:8i
//   rsp_valid  response present (registered)
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data, 0 for stores and errors (registered)
//   rsp_err    request was misaligned or out of range (registered)

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        req_ready_nxt;
  logic        rsp_valid_nxt;
  logic        accept;
  logic        access;

  // Request captured at acceptance
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  // Request as seen by the access edge
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH];

  // Byte-lane merge for stores: enabled lanes take new data, the rest keep
  // the current word contents.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // With LATENCY = 0 the access happens on the accept edge itself, so the
  // live request inputs are used; otherwise the latched copy is used.
  always_comb begin
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    req_ready_nxt = req_ready;
    rsp_valid_nxt = rsp_valid;
    accept        = 1'b0;
    access        = 1'b0;
    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          accept        = 1'b1;
          req_ready_nxt = 1'b0;
          cnt_nxt       = LAT;
          if (LAT == 4'd0) begin
            access        = 1'b1;
            rsp_valid_nxt = 1'b1;
            state_nxt     = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // The edge that leaves WAIT is the access edge.
        if (cnt <= 4'd1) begin
          access        = 1'b1;
          cnt_nxt       = 4'd0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = 4'd0;
        req_ready_nxt = 1'b1;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
    end
  end

  // Request capture on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Response data, updated only on the access edge so it stays stable
  // through any back-pressure in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
    end
  end

  // Data RAM; reset clears every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (access && acc_write && !acc_err) begin
      mem[acc_idx] <= merge_bytes(mem[acc_idx], acc_wdata, acc_be);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Issue one request; the expected response is queued after the accept edge.
  task automatic send(input bit sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] er, input logic ee);
    int   n;
    exp_t e;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    if (sel) req_valid_b = 1'b1;
    else     req_valid_a = 1'b1;
    n = 0;
    while (((sel ? req_ready_b : req_ready_a) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      note_fail(sel ? "b_req_ready_wait" : "a_req_ready_wait");
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    e.rdata = er;
    e.err   = ee;
    e.t_acc = cyc;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? q_b.size() : q_a.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? q_b.size() : q_a.size()) != 0) note_fail(sel ? "b_drain" : "a_drain");
  endtask

  // Monitor for the LATENCY=2 instance
  initial begin
    bit          seen;
    logic [31:0] hold_d;
    logic        hold_e;
    exp_t        e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (rsp_valid_a) begin
        if (!seen) begin
          seen   = 1'b1;
          hold_d = rsp_rdata_a;
          hold_e = rsp_err_a;
          if (q_a.size() == 0) note_fail("a_unexpected_rsp");
          else chk("a_latency", cyc - q_a[0].t_acc, 2);
        end else begin
          chk("a_hold_rdata", rsp_rdata_a, hold_d);
          chk("a_hold_err", rsp_err_a, hold_e);
        end
        chk("a_req_ready_in_resp", req_ready_a, 0);
        if (rsp_ready) begin
          seen = 1'b0;
          if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a_rdata", rsp_rdata_a, e.rdata);
            chk("a_err", rsp_err_a, e.err);
          end
        end
      end else if (q_a.size() != 0) begin
        chk("a_req_ready_busy", req_ready_a, 0);
      end
    end
  end

  // Monitor for the LATENCY=0 instance
  initial begin
    bit          seen;
    logic [31:0] hold_d;
    logic        hold_e;
    exp_t        e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (rsp_valid_b) begin
        if (!seen) begin
          seen   = 1'b1;
          hold_d = rsp_rdata_b;
          hold_e = rsp_err_b;
          if (q_b.size() == 0) note_fail("b_unexpected_rsp");
          else chk("b_latency", cyc - q_b[0].t_acc, 0);
        end else begin
          chk("b_hold_rdata", rsp_rdata_b, hold_d);
          chk("b_hold_err", rsp_err_b, hold_e);
        end
        chk("b_req_ready_in_resp", req_ready_b, 0);
        if (rsp_ready) begin
          seen = 1'b0;
          if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b_rdata", rsp_rdata_b, e.rdata);
            chk("b_err", rsp_err_b, e.err);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst         = 1'b1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_write   = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    req_be      = 4'h0;
    rsp_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_req_ready", req_ready_a, 1);
    chk("rst_a_rsp_valid", rsp_valid_a, 0);
    chk("rst_a_rsp_rdata", rsp_rdata_a, 0);
    chk("rst_a_rsp_err", rsp_err_a, 0);
    chk("rst_b_req_ready", req_ready_b, 1);
    chk("rst_b_rsp_valid", rsp_valid_b, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_a_req_ready", req_ready_a, 1);
    chk("idle_a_rsp_valid", rsp_valid_a, 0);

    // Full-word store, then read back; partial stores merge byte lanes
    send(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    send(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    send(0, 1, 32'h10, 32'h00001122, 4'b0011, 32'h0, 0);
    send(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD1122, 0);
    send(0, 1, 32'h10, 32'hAB000000, 4'b1000, 32'h0, 0);
    send(0, 0, 32'h10, 32'h0, 4'h0, 32'hABAD1122, 0);
    send(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 0);
    send(0, 0, 32'h10, 32'h0, 4'h0, 32'hABAD1122, 0);

    // Error cases leave RAM alone
    send(0, 0, 32'h13, 32'h0, 4'h0, 32'h0, 1);
    send(0, 1, 32'h0, 32'h12345678, 4'hF, 32'h0, 0);
    send(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    send(0, 0, 32'h0, 32'h0, 4'h0, 32'h12345678, 0);
    send(0, 0, 32'h400, 32'h0, 4'h0, 32'h0, 1);
    send(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    send(0, 0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    send(0, 0, 32'h3FF, 32'h0, 4'h0, 32'h0, 1);
    drain(0);

    // Back-pressure: response held 5 cycles, stray request ignored
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    send(0, 0, 32'h10, 32'h0, 4'h0, 32'hABAD1122, 0);
    n = 0;
    while (!rsp_valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_a) note_fail("a_bp_rsp_valid_wait");
    @(negedge clk);
    req_write   = 1'b1;
    req_addr    = 32'h10;
    req_wdata   = 32'h0;
    req_be      = 4'hF;
    req_valid_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_bp_still_valid", rsp_valid_a, 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain(0);
    send(0, 0, 32'h10, 32'h0, 4'h0, 32'hABAD1122, 0);
    drain(0);

    // Zero-latency instance
    send(1, 1, 32'h8, 32'h55AA55AA, 4'hF, 32'h0, 0);
    send(1, 0, 32'h8, 32'h0, 4'h0, 32'h55AA55AA, 0);
    send(1, 0, 32'h2, 32'h0, 4'h0, 32'h0, 1);
    drain(1);

    // Reset while a store waits: store discarded, RAM cleared
    send(0, 1, 32'h20, 32'hAAAA5555, 4'hF, 32'h0, 0);
    @(negedge clk);
    chk("a_wait_req_ready", req_ready_a, 0);
    rst = 1'b1;
    q_a.delete();
    @(negedge clk);
    chk("a_midrst_req_ready", req_ready_a, 1);
    chk("a_midrst_rsp_valid", rsp_valid_a, 0);
    rst = 1'b0;
    send(0, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0);
    send(0, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0);
    send(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0);
    send(1, 0, 32'h8, 32'h0, 4'h0, 32'h0, 0);
    drain(0);
    drain(1);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
